sdram_emu: RTL and testbench

SDRAM_EMU -- requirements
Module: sdram_emu

---
 rtl/sdram_pkg.sv | 34 +++
 rtl/sdram_emu_ram.sv | 23 ++
 rtl/sdram_emu.sv | 166 ++++++++++++++++
 tb/tb_sdram_emu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-register field positions and CAS-latency limits.
package sdram_pkg;

  // {nCS, nRAS, nCAS, nWE}; any encoding with nCS=1 is INHIBIT and decodes to CmdNop.
  typedef enum logic [3:0] {
    CmdLoadMode    = 4'b0000,
    CmdAutoRefresh = 4'b0001,
    CmdPrecharge   = 4'b0010,
    CmdActive      = 4'b0011,
    CmdWrite       = 4'b0100,
    CmdRead        = 4'b0101,
    CmdBurstTerm   = 4'b0110,
    CmdNop         = 4'b0111
  } sdram_cmd_e;

  localparam int unsigned ModeBlLsb = 0;
  localparam int unsigned ModeBlMsb = 2;
  localparam int unsigned ModeClLsb = 4;
  localparam int unsigned ModeClMsb = 6;

  localparam int unsigned ClMin = 2;
  localparam int unsigned ClMax = 3;

  localparam int unsigned ApBit = 10;
  localparam int unsigned BankW = 2;
  localparam int unsigned RowW  = 13;
  localparam int unsigned ColW  = 9;

  function automatic sdram_cmd_e decode_cmd(input logic cke, input logic [3:0] bits);
    if (!cke || bits[3]) return CmdNop;
    return sdram_cmd_e'(bits);
  endfunction

endpackage

// File: rtl/sdram_emu_ram.sv
// Single-port backing store: byte-enable write, registered read-first output.
module sdram_emu_ram #(
  parameter int unsigned AddrW = 14
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [1:0]       be_i,
  input  logic [15:0]      wdata_i,
  output logic [15:0]      rdata_o
);

  logic [15:0] mem_q [2**AddrW];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_emu.sv
// Behavioural SDRAM device emulator with CL 2/3 read pipeline and refresh counter.
// Define SDRAM_EMU_CHECK_EN to build the sticky protocol checker driving err.
module sdram_emu
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic        clk,
  input  logic        init,
  input  logic        SDRAM_CKE,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic [1:0]  SDRAM_BA,
  input  logic [12:0] SDRAM_A,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        err,
  output logic [15:0] ref_cnt
);

  sdram_cmd_e                    cmd;
  logic                          is_read;
  logic                          is_write;
  logic [BankW+RowW+ColW-1:0]    full_addr;
  logic [1:0]                    ram_be;
  logic [15:0]                   ram_rdata;
  logic [15:0]                   rd_masked;

  logic [3:0]                    open_q;
  logic [RowW-1:0]               row_q [4];
  logic [2:0]                    cl_q;
  logic [15:0]                   ref_cnt_q;

  logic                          s1_valid_q;
  logic                          s1_cl3_q;
  logic [1:0]                    s1_mask_q;
  logic                          s2_valid_q;
  logic [15:0]                   s2_data_q;
  logic                          dq_oe_q;
  logic [15:0]                   dq_out_q;

  always_comb begin
    cmd       = decode_cmd(SDRAM_CKE, {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE});
    is_read   = (cmd == CmdRead);
    is_write  = (cmd == CmdWrite);
    full_addr = {SDRAM_BA, row_q[SDRAM_BA], SDRAM_A[ColW-1:0]};
    ram_be    = (is_write && !init) ? ~{SDRAM_DQMH, SDRAM_DQML} : 2'b00;
    rd_masked = {s1_mask_q[1] ? 8'h00 : ram_rdata[15:8],
                 s1_mask_q[0] ? 8'h00 : ram_rdata[7:0]};
  end

  // A[9] has no role in column addressing; high address bits drop off when ADDR_W < 24.
  logic unused_bits;
  assign unused_bits = ^{SDRAM_A[9], full_addr};

  sdram_emu_ram #(
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (full_addr[ADDR_W-1:0]),
    .be_i    (ram_be),
    .wdata_i (dq_in),
    .rdata_o (ram_rdata)
  );

  // Open rows survive init; only the open flags are cleared.
  always_ff @(posedge clk) begin
    if (!init && cmd == CmdActive) row_q[SDRAM_BA] <= SDRAM_A;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      open_q    <= '0;
      cl_q      <= 3'(ClMin);
      ref_cnt_q <= '0;
    end else begin
      case (cmd)
        CmdActive:      open_q[SDRAM_BA] <= 1'b1;
        CmdPrecharge: begin
          if (SDRAM_A[ApBit]) open_q <= '0;
          else                open_q[SDRAM_BA] <= 1'b0;
        end
        CmdRead, CmdWrite: begin
          if (SDRAM_A[ApBit]) open_q[SDRAM_BA] <= 1'b0;
        end
        CmdAutoRefresh: ref_cnt_q <= ref_cnt_q + 16'd1;
        CmdLoadMode:    cl_q <= SDRAM_A[ModeClMsb:ModeClLsb];
        default:        ;
      endcase
    end
  end

  // Stage 1 waits on the RAM read; CL=3 reads take one more hop through stage 2.
  always_ff @(posedge clk) begin
    if (init) begin
      s1_valid_q <= 1'b0;
      s1_cl3_q   <= 1'b0;
      s1_mask_q  <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
    end else begin
      s1_valid_q <= is_read;
      s1_cl3_q   <= (cl_q == 3'(ClMax));
      s1_mask_q  <= {SDRAM_DQMH, SDRAM_DQML};
      s2_valid_q <= s1_valid_q && s1_cl3_q;
      s2_data_q  <= rd_masked;
      if (s2_valid_q) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= s2_data_q;
      end else if (s1_valid_q && !s1_cl3_q) begin
        dq_oe_q  <= 1'b1;
        dq_out_q <= rd_masked;
      end else begin
        dq_oe_q  <= 1'b0;
        dq_out_q <= '0;
      end
    end
  end

  assign dq_oe   = dq_oe_q;
  assign dq_out  = dq_out_q;
  assign ref_cnt = ref_cnt_q;

`ifdef SDRAM_EMU_CHECK_EN
  logic mode_set_q;
  logic err_q;
  logic viol;
  logic [2:0] mode_cl;

  // NOP, INHIBIT and BURST_TERMINATE are idle cycles and always legal.
  always_comb begin
    viol    = 1'b0;
    mode_cl = SDRAM_A[ModeClMsb:ModeClLsb];
    case (cmd)
      CmdRead, CmdWrite: viol = !open_q[SDRAM_BA] || !mode_set_q;
      CmdActive:         viol = open_q[SDRAM_BA] || !mode_set_q;
      CmdAutoRefresh:    viol = |open_q;
      CmdLoadMode:       viol = (mode_cl != 3'(ClMin) && mode_cl != 3'(ClMax)) ||
                                (SDRAM_A[ModeBlMsb:ModeBlLsb] != 3'b000);
      default:           viol = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      mode_set_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (viol) err_q <= 1'b1;
      if (cmd == CmdLoadMode) mode_set_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_emu.sv
// Directed bench for sdram_emu: an abstract device model plus cycle-pinned literal checks.
module tb_sdram_emu;

  localparam int unsigned ADDR_W = 14;

  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        init;
  logic        cke;
  logic        ncs, nras, ncas, nwe;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        dqml, dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        err;
  logic [15:0] ref_cnt;

  always #5 clk = ~clk;

  sdram_emu #(
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .init       (init),
    .SDRAM_CKE  (cke),
    .SDRAM_nCS  (ncs),
    .SDRAM_nRAS (nras),
    .SDRAM_nCAS (ncas),
    .SDRAM_nWE  (nwe),
    .SDRAM_BA   (ba),
    .SDRAM_A    (a),
    .SDRAM_DQML (dqml),
    .SDRAM_DQMH (dqmh),
    .dq_in      (dq_in),
    .dq_out     (dq_out),
    .dq_oe      (dq_oe),
    .err        (err),
    .ref_cnt    (ref_cnt)
  );

  int vectors = 0;
  int misses  = 0;

  // Device model: word store, bank table, and a queue of (edge due, data) read returns.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] mem_m [int];
  bit          m_open [4];
  logic [12:0] m_row  [4];
  int          m_cl;
  bit          m_mode;
  logic [15:0] m_ref;
  bit          m_err;
  int          m_edge = 0;
  rd_t         pend [$];
  bit          checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, m_edge);
    end
  endtask

  function automatic int word_addr(input logic [1:0] b, input logic [12:0] r,
                                   input logic [8:0] c);
    longint full;
    full = longint'(b) * 4194304 + longint'(r) * 512 + longint'(c);
    return int'(full % (longint'(1) << ADDR_W));
  endfunction

  task automatic model_edge();
    logic [3:0]  c;
    bit          viol;
    bit          any_open;
    int          addr;
    logic [15:0] w;
    m_edge++;
    while (pend.size() > 0 && pend[0].due <= m_edge) void'(pend.pop_front());
    if (init) begin
      for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
      m_cl   = 2;
      m_mode = 1'b0;
      m_ref  = 16'h0000;
      m_err  = 1'b0;
      pend.delete();
      return;
    end
    if (!cke || ncs) return;
    c        = {ncs, nras, ncas, nwe};
    viol     = 1'b0;
    any_open = 1'b0;
    for (int i = 0; i < 4; i++) if (m_open[i]) any_open = 1'b1;
    addr = word_addr(ba, m_row[ba], a[8:0]);
    w    = mem_m.exists(addr) ? mem_m[addr] : 16'h0000;
    case (c)
      ACT: begin
        viol      = m_open[ba] || !m_mode;
        m_open[ba] = 1'b1;
        m_row[ba]  = a;
      end
      PRE: begin
        if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        else m_open[ba] = 1'b0;
      end
      REF: begin
        viol  = any_open;
        m_ref = m_ref + 16'd1;
      end
      LMR: begin
        viol   = !(a[6:4] == 3'd2 || a[6:4] == 3'd3) || a[2:0] != 3'd0;
        m_cl   = (a[6:4] == 3'd3) ? 3 : 2;
        m_mode = 1'b1;
      end
      WR: begin
        viol = !m_open[ba] || !m_mode;
        if (!dqmh) w[15:8] = dq_in[15:8];
        if (!dqml) w[7:0]  = dq_in[7:0];
        mem_m[addr] = w;
        if (a[10]) m_open[ba] = 1'b0;
      end
      RD: begin
        viol = !m_open[ba] || !m_mode;
        if (dqmh) w[15:8] = 8'h00;
        if (dqml) w[7:0]  = 8'h00;
        pend.push_back('{due: m_edge + m_cl, data: w});
        if (a[10]) m_open[ba] = 1'b0;
      end
      default: ;
    endcase
`ifdef SDRAM_EMU_CHECK_EN
    if (viol) m_err = 1'b1;
`else
    if (viol) m_err = m_err;
`endif
  endtask

  // Drive one command for one edge; returns 1 ns after the edge.
  task automatic tick(input logic [3:0] c, input logic [1:0] b = 2'd0,
                      input logic [12:0] addr = 13'd0, input logic [15:0] d = 16'd0,
                      input logic [1:0] dqm = 2'b00);
    {ncs, nras, ncas, nwe} = c;
    ba    = b;
    a     = addr;
    dq_in = d;
    {dqmh, dqml} = dqm;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    bit exp_oe;
    if (checking) begin
      exp_oe = pend.size() > 0 && pend[0].due == m_edge + 1;
      check("cyc_dq_oe", 32'(dq_oe), 32'(exp_oe));
      if (exp_oe) check("cyc_dq_out", 32'(dq_out), 32'(pend[0].data));
      check("cyc_ref_cnt", 32'(ref_cnt), 32'(m_ref));
      check("cyc_err", 32'(err), 32'(m_err));
    end
  end

  initial begin
    init  = 1'b0;
    cke   = 1'b1;
    {ncs, nras, ncas, nwe} = NOP;
    ba    = 2'd0;
    a     = 13'd0;
    dqml  = 1'b1;
    dqmh  = 1'b1;
    dq_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;

    // Init sequence
    init = 1'b1;
    tick(NOP);
    init = 1'b0;
    checking = 1'b1;
    check("rst_dq_oe", 32'(dq_oe), 0);
    check("rst_dq_out", 32'(dq_out), 0);
    check("rst_ref_cnt", 32'(ref_cnt), 0);
    check("rst_err", 32'(err), 0);
    tick(PRE, 2'd0, 13'h0400);
    repeat (8) tick(REF);
    tick(LMR, 2'd0, 13'h0220);
    check("init_ref_cnt", 32'(ref_cnt), 8);
    check("init_err", 32'(err), 0);

    // Masked write then CL=2 read, both with auto-precharge
    tick(ACT, 2'd0, 13'h0012);
    tick(WR, 2'd0, 13'h0405, 16'hA55A, 2'b01);
    tick(ACT, 2'd0, 13'h0012);
    tick(RD, 2'd0, 13'h0405, 16'h0000, 2'b01);
    check("cl2_t_oe", 32'(dq_oe), 0);
    tick(BST);
    check("cl2_t1_oe", 32'(dq_oe), 1);
    check("cl2_t1_data", 32'(dq_out), 32'h0000_A500);
    tick(NOP);
    check("cl2_t2_oe", 32'(dq_oe), 0);

    // CL=3 back-to-back reads
    tick(LMR, 2'd0, 13'h0230);
    tick(ACT, 2'd1, 13'h0003);
    tick(WR, 2'd1, 13'h0010, 16'h1111);
    tick(WR, 2'd1, 13'h0011, 16'h2222);
    tick(RD, 2'd1, 13'h0010);
    check("cl3_t_oe", 32'(dq_oe), 0);
    tick(RD, 2'd1, 13'h0011);
    check("cl3_t1_oe", 32'(dq_oe), 0);
    tick(NOP);
    check("cl3_first", 32'(dq_out), 32'h1111);
    tick(NOP);
    check("cl3_second", 32'(dq_out), 32'h2222);
    check("cl3_second_oe", 32'(dq_oe), 1);
    tick(NOP);
    check("cl3_done_oe", 32'(dq_oe), 0);

    // CL=2: read then write to same word, then read-after-write, then pipelined reads
    tick(LMR, 2'd0, 13'h0220);
    tick(RD, 2'd1, 13'h0010);
    tick(WR, 2'd1, 13'h0010, 16'h3333);
    check("rd_before_wr", 32'(dq_out), 32'h1111);
    tick(RD, 2'd1, 13'h0010);
    check("raw_gap_oe", 32'(dq_oe), 0);
    tick(RD, 2'd1, 13'h0011, 16'h0000, 2'b10);
    check("rd_after_wr", 32'(dq_out), 32'h3333);
    tick(NOP);
    check("dqmh_zeroed", 32'(dq_out), 32'h0022);
    tick(NOP);
    tick(PRE, 2'd0, 13'h0400);

    // Read to a never-activated bank
    tick(RD, 2'd2, 13'h0000, 16'h0000, 2'b11);
`ifdef SDRAM_EMU_CHECK_EN
    check("closed_bank_err", 32'(err), 1);
    repeat (3) tick(NOP);
    check("closed_bank_err_held", 32'(err), 1);
`else
    check("closed_bank_err", 32'(err), 0);
    repeat (3) tick(NOP);
    check("closed_bank_err_held", 32'(err), 0);
`endif
    init = 1'b1;
    tick(NOP);
    init = 1'b0;
    check("err_cleared", 32'(err), 0);
    tick(PRE, 2'd0, 13'h0400);
    tick(LMR, 2'd0, 13'h0220);

    // init one edge after a READ cancels it; store survives
    tick(ACT, 2'd3, 13'h0007);
    tick(WR, 2'd3, 13'h0020, 16'hBEEF);
    tick(RD, 2'd3, 13'h0020);
    init = 1'b1;
    tick(NOP);
    init = 1'b0;
    check("cancel_oe0", 32'(dq_oe), 0);
    tick(NOP);
    check("cancel_oe1", 32'(dq_oe), 0);
    tick(NOP);
    check("cancel_oe2", 32'(dq_oe), 0);
    tick(LMR, 2'd0, 13'h0220);
    tick(ACT, 2'd3, 13'h0007);
    tick(RD, 2'd3, 13'h0420);
    tick(NOP);
    check("survive_init", 32'(dq_out), 32'hBEEF);

    // CKE=0 ignores commands
    tick(ACT, 2'd3, 13'h0007);
    cke = 1'b0;
    tick(WR, 2'd3, 13'h0020, 16'hFFFF);
    tick(REF);
    cke = 1'b1;
    tick(RD, 2'd3, 13'h0420);
    tick(NOP);
    check("cke_low_write", 32'(dq_out), 32'hBEEF);
    check("cke_low_ref", 32'(ref_cnt), 0);

    // Refresh counter wrap
    init = 1'b1;
    tick(NOP);
    init = 1'b0;
    repeat (65535) tick(REF);
    check("ref_max", 32'(ref_cnt), 32'hFFFF);
    tick(REF);
    check("ref_wrap", 32'(ref_cnt), 0);
    tick(NOP);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
